// File: rtl/level_probe_encoder_if.sv
// Level probe bus: raw probe switches in, encoded tank level and status out.
//   probe         : raw float/probe switches (bit 0 = 25 %, bit 3 = 100 %)
//   level_code    : encoded level 0..4 (0/25/50/75/100 %)
//   level_valid   : level_code reflects a currently valid probe pattern
//   level_changed : one-cycle pulse when level_code takes a new value
//   fault         : persistent sensor fault
// master drives the probes (sensor side), slave is the encoder.
interface level_probe_encoder_if;
    logic [3:0] probe;
    logic [2:0] level_code;
    logic       level_valid;
    logic       level_changed;
    logic       fault;

    modport master (
        output probe,
        input  level_code,
        input  level_valid,
        input  level_changed,
        input  fault
    );

    modport slave (
        input  probe,
        output level_code,
        output level_valid,
        output level_changed,
        output fault
    );
endinterface

// File: rtl/level_probe_encoder.sv
// Tank level probe encoder.
// Synchronises and debounces four discrete probe switches, checks that the
// debounced probes form a thermometer pattern, encodes it into a 3-bit level
// code and raises a fault when the pattern stays invalid for too long.
// Ports:
//   clk : system clock
//   rst : asynchronous reset, active-high
//   bus : level_probe_encoder_if.slave (probe in; level_code, level_valid,
//         level_changed, fault out, all registered)
module level_probe_encoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FAULT_CYCLES    = 64,
    parameter int INVERT_PROBES   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    level_probe_encoder_if.slave  bus
);

    localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FCW = $clog2(FAULT_CYCLES + 1);
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DCW-1:0] DEB_ONE  = DCW'(1);
    localparam logic [DCW-1:0] DEB_ZERO = DCW'(0);
    localparam logic [FCW-1:0] FLT_LAST = FCW'(FAULT_CYCLES - 1);
    localparam logic [FCW-1:0] FLT_ONE  = FCW'(1);
    localparam logic [FCW-1:0] FLT_ZERO = FCW'(0);

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    // Returns {valid, code}: thermometer patterns map to 0..4, anything else
    // is invalid and carries code 0 so an out-of-range value never escapes.
    function automatic logic [3:0] decode_level(input logic [3:0] pat);
        logic [3:0] res;
        case (pat)
            4'b0000: res = {1'b1, 3'd0};
            4'b0001: res = {1'b1, 3'd1};
            4'b0011: res = {1'b1, 3'd2};
            4'b0111: res = {1'b1, 3'd3};
            4'b1111: res = {1'b1, 3'd4};
            default: res = {1'b0, 3'd0};
        endcase
        return res;
    endfunction

    logic [3:0]     sync1_r;
    logic [3:0]     sync2_r;
    logic [3:0]     sp_s;
    logic [3:0]     deb_r;
    logic [DCW-1:0] cnt_r [4];

    state_t         state_r;
    state_t         state_nxt_s;
    logic [FCW-1:0] fcnt_r;
    logic [FCW-1:0] fcnt_nxt_s;
    logic [2:0]     level_code_r;
    logic [2:0]     code_nxt_s;
    logic           level_valid_r;
    logic           level_changed_r;
    logic           fault_r;
    logic [3:0]     dec_s;
    logic           pat_valid_s;
    logic [2:0]     pat_code_s;

    // Two-flop synchroniser for the asynchronous probe switches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
        end else begin
            sync1_r <= bus.probe;
            sync2_r <= sync1_r;
        end
    end

    // Polarity correction so that 1 always means wetted downstream.
    always_comb begin
        if (INVERT_PROBES != 0) begin
            sp_s = ~sync2_r;
        end else begin
            sp_s = sync2_r;
        end
    end

    // Per-probe debounce: deb follows sp only after it has differed for
    // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_r <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= DEB_ZERO;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sp_s[i] == deb_r[i]) begin
                    cnt_r[i] <= DEB_ZERO;
                end else if (cnt_r[i] == DEB_LAST) begin
                    deb_r[i] <= sp_s[i];
                    cnt_r[i] <= DEB_ZERO;
                end else begin
                    cnt_r[i] <= cnt_r[i] + DEB_ONE;
                end
            end
        end
    end

    // Pattern decode of the debounced probes.
    always_comb begin
        dec_s       = decode_level(deb_r);
        pat_valid_s = dec_s[3];
        pat_code_s  = dec_s[2:0];
    end

    // Next-state logic: OK tracks the level, SUSPECT tolerates short invalid
    // stretches, FAULT needs a sustained valid run before releasing.
    always_comb begin
        state_nxt_s = state_r;
        fcnt_nxt_s  = fcnt_r;
        code_nxt_s  = level_code_r;
        case (state_r)
            ST_OK: begin
                if (pat_valid_s) begin
                    code_nxt_s = pat_code_s;
                    fcnt_nxt_s = FLT_ZERO;
                end else if (FAULT_CYCLES == 1) begin
                    state_nxt_s = ST_FAULT;
                    fcnt_nxt_s  = FLT_ZERO;
                end else begin
                    state_nxt_s = ST_SUSPECT;
                    fcnt_nxt_s  = FLT_ONE;
                end
            end
            ST_SUSPECT: begin
                if (pat_valid_s) begin
                    state_nxt_s = ST_OK;
                    code_nxt_s  = pat_code_s;
                    fcnt_nxt_s  = FLT_ZERO;
                end else if (fcnt_r == FLT_LAST) begin
                    state_nxt_s = ST_FAULT;
                    fcnt_nxt_s  = FLT_ZERO;
                end else begin
                    fcnt_nxt_s = fcnt_r + FLT_ONE;
                end
            end
            ST_FAULT: begin
                if (pat_valid_s) begin
                    if (fcnt_r == FLT_LAST) begin
                        state_nxt_s = ST_OK;
                        code_nxt_s  = pat_code_s;
                        fcnt_nxt_s  = FLT_ZERO;
                    end else begin
                        fcnt_nxt_s = fcnt_r + FLT_ONE;
                    end
                end else begin
                    fcnt_nxt_s = FLT_ZERO;
                end
            end
            default: begin
                state_nxt_s = ST_OK;
                fcnt_nxt_s  = FLT_ZERO;
                code_nxt_s  = level_code_r;
            end
        endcase
    end

    // State, counter and registered outputs; status flags are derived from
    // the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= ST_OK;
            fcnt_r          <= FLT_ZERO;
            level_code_r    <= 3'd0;
            level_valid_r   <= 1'b0;
            level_changed_r <= 1'b0;
            fault_r         <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            fcnt_r          <= fcnt_nxt_s;
            level_code_r    <= code_nxt_s;
            level_valid_r   <= (state_nxt_s == ST_OK);
            level_changed_r <= (code_nxt_s != level_code_r);
            fault_r         <= (state_nxt_s == ST_FAULT);
        end
    end

    assign bus.level_code    = level_code_r;
    assign bus.level_valid   = level_valid_r;
    assign bus.level_changed = level_changed_r;
    assign bus.fault         = fault_r;

endmodule

// File: doc/level_probe_encoder.md
Name: level_probe_encoder

Overview:
- Produces the 3-bit tank level code (0..4 = 0/25/50/75/100 %) that the pump controller consumes. One instance per tank, inferior and superior.
- Inputs are four discrete float/probe switches, asynchronous and bouncy.
- Per probe, the block synchronises and debounces the switch.
- It validates that the four debounced probes form a thermometer pattern, encodes it, and flags a persistent sensor fault.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a probe's debounced value follows its synchronised value (>=1).
- FAULT_CYCLES, 64, consecutive invalid-pattern cycles before fault asserts; also consecutive valid-pattern cycles needed to leave fault (>=1).
- INVERT_PROBES, 0, 1 = probes active-low (inverted after the synchroniser).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- probe  input  4  raw probe switches; probe[0]=25 %, probe[1]=50 %, probe[2]=75 %, probe[3]=100 %; 1 = wetted (after INVERT_PROBES)
- level_code  output  3  encoded level 0..4, registered
- level_valid  output  1  1 when level_code reflects a currently valid pattern (state OK)
- level_changed  output  1  one-cycle pulse on the cycle level_code takes a new value
- fault  output  1  1 while in state FAULT

Behaviour:
- Reset (async, rst=1):
  - sync flops, debounced probes and all counters = 0
  - level_code=0, level_valid=0, level_changed=0, fault=0
  - state=OK
- Synchroniser: 2 flops per probe. INVERT_PROBES is applied to the second flop's output (sp).
- Debounce, per probe independently:
  - Counter cnt, width $clog2(DEBOUNCE_CYCLES+1).
  - If sp == deb, cnt <= 0.
  - Else, if cnt == DEBOUNCE_CYCLES-1: deb <= sp and cnt <= 0.
  - Else cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches deb.
- Pattern decode (combinational on deb):
  - 0000->0, 0001->1, 0011->2, 0111->3, 1111->4.
  - All other 11 patterns are invalid.
- State machine (states OK, SUSPECT, FAULT) with one counter fcnt, width $clog2(FAULT_CYCLES+1):
  - OK, pattern valid: level_code <= decoded value; level_valid=1.
  - OK, pattern invalid: -> SUSPECT, fcnt <= 1, level_code held, level_valid <= 0.
  - SUSPECT, pattern valid: -> OK, level_code <= decoded, level_valid <= 1, fcnt <= 0.
  - SUSPECT, pattern invalid: fcnt <= fcnt+1. When fcnt == FAULT_CYCLES-1 and still invalid: -> FAULT, fault <= 1, fcnt <= 0.
  - FAULT, pattern valid: fcnt <= fcnt+1, level_code held. When fcnt == FAULT_CYCLES-1: -> OK, fault <= 0, level_code <= decoded, level_valid <= 1, fcnt <= 0.
  - FAULT, pattern invalid: fcnt <= 0.
  - FAULT_CYCLES=1: entry and exit happen on the first qualifying cycle.
- level_code in non-OK states:
  - In SUSPECT and FAULT, level_code holds the last valid value. It is never driven with an invalid or out-of-range value.
  - The code is always <= 4.
- level_changed: registered, asserted for exactly one cycle when the level_code register loads a value different from its previous value. A reload with the same value gives no pulse.
- Latency: a clean probe step, applied before edge k and held, appears on level_code after edge k+DEBOUNCE_CYCLES+2:
  - 2 synchroniser edges
  - DEBOUNCE_CYCLES debounce edges
  - output register merged into the last debounce edge's following cycle
  - level_changed rises on the same edge as level_code.
- Simultaneous probe changes: each probe debounces independently. Intermediate invalid patterns shorter than FAULT_CYCLES cause only a brief SUSPECT, with level_valid low and no fault.
- Reset asserted mid-operation: everything returns to reset values immediately, regardless of state or counters.

Test Plan (DEBOUNCE_CYCLES=4, FAULT_CYCLES=8, INVERT_PROBES=0 unless stated):
- Reset release with probe=4'b0000 -> level_code=0, level_valid=1 from the first cycle after reset; fault=0; no level_changed.
- probe 0000->0011, held -> level_code=2 exactly 6 edges later; level_changed high for one cycle; level_valid stays 1.
- probe[1] pulsed high for 3 cycles from 0001 -> deb unchanged, level_code stays 1, no level_changed, state stays OK.
- probe=0101 held -> SUSPECT (level_valid=0, level_code holds 1); fault=1 after 8 invalid cycles; probe=0111 held -> fault stays 1 for 8 valid cycles, then fault=0, level_code=3, level_valid=1, level_changed pulse.
- Invalid pattern for 5 cycles then valid 1111 -> no fault; level_code=4 on return to OK.
- INVERT_PROBES=1, probe=4'b1000 -> level_code=3.
- rst asserted mid-SUSPECT -> all outputs 0 immediately.
